// File: rtl/apb1_arbiter.sv
// apb1_arbiter: two-master arbiter in front of the APB1 peripheral slave port.
// Master 0 is the AHB-to-APB bridge (CPU path) and master 1 is the DMA/debug path.
// The arbiter runs one registered APB transfer at a time and routes the slave
// response back to the master that owns the transfer.
// Arbitration is round-robin, or master 0 wins ties when FIXED_PRIO = 1.
// A wait-state timeout ends a stalled ACCESS with an error.
//
// Ports:
//   apb1_root_clk / apb1_root_rstn : clock, synchronous active-low reset
//   mN_psel/penable/pwrite/paddr/pwdata/pstrb/pprot : master N request side
//   mN_prdata/pready/pslverr                        : master N response side
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot    : APB1 bus request side
//   prdata/pready/pslverr                           : APB1 bus response side
//   grant       : index of the master owning the current or last transfer
//   arb_timeout : one-cycle pulse when a transfer is ended by the timeout
module apb1_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  apb1_root_clk,
  input  logic                  apb1_root_rstn,
  input  logic                  m0_psel,
  input  logic                  m0_penable,
  input  logic                  m0_pwrite,
  input  logic [ADDR_WIDTH-1:0] m0_paddr,
  input  logic [31:0]           m0_pwdata,
  input  logic [3:0]            m0_pstrb,
  input  logic [2:0]            m0_pprot,
  output logic [31:0]           m0_prdata,
  output logic                  m0_pready,
  output logic                  m0_pslverr,
  input  logic                  m1_psel,
  input  logic                  m1_penable,
  input  logic                  m1_pwrite,
  input  logic [ADDR_WIDTH-1:0] m1_paddr,
  input  logic [31:0]           m1_pwdata,
  input  logic [3:0]            m1_pstrb,
  input  logic [2:0]            m1_pprot,
  output logic [31:0]           m1_prdata,
  output logic                  m1_pready,
  output logic                  m1_pslverr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  output logic [3:0]            pstrb,
  output logic [2:0]            pprot,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  grant,
  output logic                  arb_timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam bit         TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_t     state, state_nxt;
  logic       any_req;
  logic       win;
  logic       load;
  logic       timeout_hit;
  logic [7:0] tcnt;

  // Requests are level-based on psel; the masters' penable carries no extra
  // information for arbitration.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign any_req = m0_psel | m1_psel;

  // On a tie, round-robin hands the bus to the master that did not have it last.
  always_comb begin
    win = m1_psel;
    if (m0_psel && m1_psel)
      win = (FIXED_PRIO != 0) ? 1'b0 : ~grant;
  end

  assign timeout_hit = TO_EN && (state == ACCESS) && !pready && (tcnt == TO_LIM);

  // State register
  always_ff @(posedge apb1_root_clk) begin
    if (!apb1_root_rstn) state <= IDLE;
    else                 state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (timeout_hit) state_nxt = IDLE;
        else if (pready) state_nxt = any_req ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every entry into SETUP starts a new transfer, so that is where the
  // winner and its request fields are captured.
  assign load = (state_nxt == SETUP);

  always_ff @(posedge apb1_root_clk) begin
    if (!apb1_root_rstn) begin
      grant  <= 1'b1;
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
      tcnt   <= '0;
    end else begin
      if (load) begin
        grant  <= win;
        pwrite <= win ? m1_pwrite : m0_pwrite;
        paddr  <= win ? m1_paddr  : m0_paddr;
        pwdata <= win ? m1_pwdata : m0_pwdata;
        pstrb  <= win ? m1_pstrb  : m0_pstrb;
        pprot  <= win ? m1_pprot  : m0_pprot;
      end
      if (state == SETUP)                 tcnt <= '0;
      else if (state == ACCESS && !pready) tcnt <= tcnt + 8'd1;
    end
  end

  // Output logic. The response is gated by reset so that a transfer aborted
  // by reset never returns a ready to its master.
  always_comb begin
    logic        act;
    logic        r_rdy, r_err;
    logic [31:0] r_data;
    act    = apb1_root_rstn && (state == ACCESS);
    r_rdy  = pready | timeout_hit;
    r_err  = pslverr | timeout_hit;
    r_data = timeout_hit ? 32'h0 : prdata;

    psel        = (state != IDLE);
    penable     = (state == ACCESS);
    arb_timeout = apb1_root_rstn && timeout_hit;

    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m0_prdata  = 32'h0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;
    m1_prdata  = 32'h0;
    if (act && !grant) begin
      m0_pready  = r_rdy;
      m0_pslverr = r_err;
      m0_prdata  = r_data;
    end
    if (act && grant) begin
      m1_pready  = r_rdy;
      m1_pslverr = r_err;
      m1_prdata  = r_data;
    end
  end

endmodule

// File: tb/tb_apb1_arbiter.sv
// tb_apb1_arbiter: directed bench for apb1_arbiter. One instance runs
// round-robin with a 4-cycle timeout; a second instance on the same inputs
// runs fixed priority with the timeout disabled.
module tb_apb1_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_psel = 0, m0_penable = 0, m0_pwrite = 0;
  logic [31:0] m0_paddr = 0, m0_pwdata = 0;
  logic [3:0]  m0_pstrb = 0;
  logic [2:0]  m0_pprot = 0;
  logic        m1_psel = 0, m1_penable = 0, m1_pwrite = 0;
  logic [31:0] m1_paddr = 0, m1_pwdata = 0;
  logic [3:0]  m1_pstrb = 0;
  logic [2:0]  m1_pprot = 0;
  logic [31:0] prdata = 0;
  logic        pready = 0, pslverr = 0;

  logic [31:0] m0_prdata, m1_prdata, paddr, pwdata;
  logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
  logic        psel, penable, pwrite, grant, arb_timeout;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic [31:0] fp_m0_prdata, fp_m1_prdata, fp_paddr, fp_pwdata;
  logic        fp_m0_pready, fp_m0_pslverr, fp_m1_pready, fp_m1_pslverr;
  logic        fp_psel, fp_penable, fp_pwrite, fp_grant, fp_arb_timeout;
  logic [3:0]  fp_pstrb;
  logic [2:0]  fp_pprot;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb1_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(4)) dut (
    .apb1_root_clk(clk), .apb1_root_rstn(rstn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pprot(m0_pprot),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pprot(m1_pprot),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .grant(grant), .arb_timeout(arb_timeout)
  );

  apb1_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(0)) dut_fp (
    .apb1_root_clk(clk), .apb1_root_rstn(rstn),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pprot(m0_pprot),
    .m0_prdata(fp_m0_prdata), .m0_pready(fp_m0_pready), .m0_pslverr(fp_m0_pslverr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pprot(m1_pprot),
    .m1_prdata(fp_m1_prdata), .m1_pready(fp_m1_pready), .m1_pslverr(fp_m1_pslverr),
    .psel(fp_psel), .penable(fp_penable), .pwrite(fp_pwrite), .paddr(fp_paddr),
    .pwdata(fp_pwdata), .pstrb(fp_pstrb), .pprot(fp_pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .grant(fp_grant), .arb_timeout(fp_arb_timeout)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1
  // time unit after that, well away from the next edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; m0_psel = 0; m1_psel = 0; pready = 0; pslverr = 0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); #1;
    n_checks++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b want=000", {psel, penable, pwrite});
    end
    n_checks++;
    if ({paddr, pwdata, pstrb, pprot} !== 71'h0) begin
      n_fail++; $display("FAIL reset_data got=%h want=0", {paddr, pwdata, pstrb, pprot});
    end
    n_checks++;
    if (grant !== 1'b1) begin n_fail++; $display("FAIL reset_grant got=%b want=1", grant); end
    n_checks++;
    if ({arb_timeout, m0_pready, m0_pslverr, m1_pready, m1_pslverr} !== 5'b0) begin
      n_fail++; $display("FAIL reset_resp got=%b want=00000",
                         {arb_timeout, m0_pready, m0_pslverr, m1_pready, m1_pslverr});
    end
    rstn = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    pready = 1'b1; prdata = 32'hDEADBEEF;
    m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h40001004;
    tick(); #1;
    n_checks++;
    if ({psel, penable, grant} !== 3'b100 || paddr !== 32'h40001004 || m0_pready !== 1'b0) begin
      n_fail++; $display("FAIL read_setup got psel/pen/grant=%b paddr=%h rdy=%b want 100 40001004 0",
                         {psel, penable, grant}, paddr, m0_pready);
    end
    m0_psel = 1'b0;
    tick(); #1;
    n_checks++;
    if ({psel, penable} !== 2'b11 || m0_pready !== 1'b1 || m0_prdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_access got psel/pen=%b rdy=%b rdata=%h want 11 1 deadbeef",
                         {psel, penable}, m0_pready, m0_prdata);
    end
    n_checks++;
    if (m1_pready !== 1'b0 || m1_prdata !== 32'h0) begin
      n_fail++; $display("FAIL read_other got rdy=%b rdata=%h want 0 0", m1_pready, m1_prdata);
    end
    tick(); #1;
    n_checks++;
    if ({psel, penable, m0_pready} !== 3'b000) begin
      n_fail++; $display("FAIL read_idle got=%b want=000", {psel, penable, m0_pready});
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    logic        g;
    do_reset();
    pready = 1'b1; prdata = 32'h0;
    m0_psel = 1'b1; m0_paddr = 32'h40000100;
    m1_psel = 1'b1; m1_paddr = 32'h40000200;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      exp_addr = g ? 32'h40000200 : 32'h40000100;
      tick(); #1;
      n_checks++;
      if ({psel, penable} !== 2'b10 || grant !== g || paddr !== exp_addr) begin
        n_fail++; $display("FAIL rr_setup%0d got psel/pen=%b grant=%b paddr=%h want 10 %b %h",
                           k, {psel, penable}, grant, paddr, g, exp_addr);
      end
      tick(); #1;
      n_checks++;
      if ({m1_pready, m0_pready} !== (g ? 2'b10 : 2'b01) || penable !== 1'b1) begin
        n_fail++; $display("FAIL rr_access%0d got rdy1/rdy0=%b pen=%b want %b 1",
                           k, {m1_pready, m0_pready}, penable, g ? 2'b10 : 2'b01);
      end
    end
    m0_psel = 1'b0; m1_psel = 1'b0;
    tick(); #1;
    n_checks++;
    if (psel !== 1'b0) begin n_fail++; $display("FAIL rr_idle got psel=%b want 0", psel); end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    pready = 1'b1;
    m0_psel = 1'b1; m1_psel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      n_checks++;
      if ({fp_psel, fp_penable, fp_grant} !== 3'b100) begin
        n_fail++; $display("FAIL fp_setup%0d got psel/pen/grant=%b want 100",
                           k, {fp_psel, fp_penable, fp_grant});
      end
      tick(); #1;
      n_checks++;
      if ({fp_m1_pready, fp_m0_pready} !== 2'b01) begin
        n_fail++; $display("FAIL fp_access%0d got rdy1/rdy0=%b want 01", k, {fp_m1_pready, fp_m0_pready});
      end
    end
    m0_psel = 1'b0; m1_psel = 1'b0;
    tick();
  endtask

  task automatic test_wait_write();
    do_reset();
    pready = 1'b0;
    m1_psel = 1'b1; m1_pwrite = 1'b1; m1_pwdata = 32'h12345678;
    m1_pstrb = 4'hF; m1_paddr = 32'h40002000; m1_pprot = 3'b010;
    tick(); #1;
    n_checks++;
    if (grant !== 1'b1 || pwrite !== 1'b1 || pstrb !== 4'hF || pprot !== 3'b010 ||
        paddr !== 32'h40002000) begin
      n_fail++; $display("FAIL wr_setup got grant=%b pwrite=%b pstrb=%h pprot=%b paddr=%h want 1 1 f 010 40002000",
                         grant, pwrite, pstrb, pprot, paddr);
    end
    // Master-side changes after the grant must not reach the bus.
    m1_pwdata = 32'hFFFFFFFF; m1_psel = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick(); #1;
      n_checks++;
      if (penable !== 1'b1 || pwdata !== 32'h12345678 || m1_pready !== 1'b0 || m0_pready !== 1'b0) begin
        n_fail++; $display("FAIL wr_wait%0d got pen=%b pwdata=%h rdy1=%b rdy0=%b want 1 12345678 0 0",
                           w, penable, pwdata, m1_pready, m0_pready);
      end
    end
    tick();
    pready = 1'b1; #1;
    n_checks++;
    if (penable !== 1'b1 || pwdata !== 32'h12345678 || m1_pready !== 1'b1 || m0_pready !== 1'b0) begin
      n_fail++; $display("FAIL wr_done got pen=%b pwdata=%h rdy1=%b rdy0=%b want 1 12345678 1 0",
                         penable, pwdata, m1_pready, m0_pready);
    end
    tick();
    pready = 1'b0; #1;
    n_checks++;
    if ({psel, penable, m1_pready} !== 3'b000) begin
      n_fail++; $display("FAIL wr_idle got=%b want=000", {psel, penable, m1_pready});
    end
    m1_pwrite = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    pready = 1'b0; prdata = 32'hAAAA5555; pslverr = 1'b0;
    m0_psel = 1'b1; m0_paddr = 32'h40004000;
    tick();
    m0_psel = 1'b0;
    for (int w = 0; w < 4; w++) begin
      tick(); #1;
      n_checks++;
      if ({arb_timeout, m0_pready, m0_pslverr} !== 3'b000 || penable !== 1'b1) begin
        n_fail++; $display("FAIL to_wait%0d got to/rdy/err=%b pen=%b want 000 1",
                           w, {arb_timeout, m0_pready, m0_pslverr}, penable);
      end
    end
    tick(); #1;
    n_checks++;
    if ({arb_timeout, m0_pready, m0_pslverr} !== 3'b111 || m0_prdata !== 32'h0 || m1_pready !== 1'b0) begin
      n_fail++; $display("FAIL to_hit got to/rdy/err=%b rdata=%h rdy1=%b want 111 0 0",
                         {arb_timeout, m0_pready, m0_pslverr}, m0_prdata, m1_pready);
    end
    tick();
    pready = 1'b1; #1;
    n_checks++;
    if ({psel, arb_timeout, m0_pready} !== 3'b000) begin
      n_fail++; $display("FAIL to_after got psel/to/rdy=%b want 000", {psel, arb_timeout, m0_pready});
    end
    prdata = 32'h11112222;
    m1_psel = 1'b1; m1_paddr = 32'h40005000;
    tick(); #1;
    n_checks++;
    if ({psel, penable, grant} !== 3'b101) begin
      n_fail++; $display("FAIL to_m1_setup got psel/pen/grant=%b want 101", {psel, penable, grant});
    end
    m1_psel = 1'b0;
    tick(); #1;
    n_checks++;
    if ({m1_pready, m1_pslverr} !== 2'b10 || m1_prdata !== 32'h11112222 || arb_timeout !== 1'b0) begin
      n_fail++; $display("FAIL to_m1_access got rdy/err=%b rdata=%h to=%b want 10 11112222 0",
                         {m1_pready, m1_pslverr}, m1_prdata, arb_timeout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    pready = 1'b0;
    m0_psel = 1'b1; m0_pwrite = 1'b1; m0_paddr = 32'h40003000; m0_pwdata = 32'hCAFEF00D;
    tick();
    m0_psel = 1'b0;
    tick();
    // ACCESS cycle: reset arrives together with the slave's ready.
    rstn = 1'b0; pready = 1'b1; #1;
    n_checks++;
    if ({m0_pready, m1_pready} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_rdy got rdy0/rdy1=%b want 00", {m0_pready, m1_pready});
    end
    tick(); #1;
    n_checks++;
    if ({psel, penable, pwrite} !== 3'b000 || paddr !== 32'h0 || pwdata !== 32'h0 || grant !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_bus got ctrl=%b paddr=%h pwdata=%h grant=%b want 000 0 0 1",
                         {psel, penable, pwrite}, paddr, pwdata, grant);
    end
    rstn = 1'b1;
    tick(); #1;
    n_checks++;
    if ({psel, m0_pready, m1_pready} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_after got psel/rdy0/rdy1=%b want 000", {psel, m0_pready, m1_pready});
    end
    m0_pwrite = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_prio();
    test_wait_write();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
